// File: rtl/contador_modos.sv
// contador_modos: synchronous multi-mode counter (+1, -1, +3, parallel load).
// RCO is a registered one-cycle wrap pulse taken from the carry/borrow of a
// WIDTH+1-bit sum, so WIDTH-bit slices can be cascaded.
// Optional feature macro: CONTADOR_PARIDAD_EN. When defined, Paridad is the
// registered XOR-reduction of Q. When undefined, Paridad is tied to 0.
module contador_modos #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             Paridad
);

    typedef enum logic [1:0] {
        modo_sube   = 2'b00,
        modo_baja   = 2'b01,
        modo_sube3  = 2'b10,
        modo_carga  = 2'b11
    } modo_t;

    localparam logic [WIDTH:0] paso_uno  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] paso_tres = (WIDTH+1)'(3);

    modo_t            modo;
    logic [WIDTH:0]   suma;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;

    assign modo = modo_t'(MODO);

    // Next-state arithmetic in WIDTH+1 bits; the MSB is the carry/borrow.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        suma     = {1'b0, Q};
        q_next   = Q;
        rco_next = 1'b0;
        if (ENB) begin
            unique case (modo)
                modo_sube:  suma = {1'b0, Q} + paso_uno;
                modo_baja:  suma = {1'b0, Q} - paso_uno;
                modo_sube3: suma = {1'b0, Q} + paso_tres;
                modo_carga: suma = {1'b0, D};
                default:    suma = {1'b0, Q};
            endcase
            q_next = suma[WIDTH-1:0];
            // A load never flags a wrap, even when D equals Q or is zero.
            rco_next = suma[WIDTH] && (modo != modo_carga);
        end
    end

    // Count, wrap-pulse and (optionally) parity registers, all on one edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            Q       <= '0;
            RCO     <= 1'b0;
`ifdef CONTADOR_PARIDAD_EN
            Paridad <= 1'b0;
`endif
        end else begin
            Q       <= q_next;
            RCO     <= rco_next;
`ifdef CONTADOR_PARIDAD_EN
            Paridad <= ^q_next;
`endif
        end
    end

`ifndef CONTADOR_PARIDAD_EN
    // Parity disabled: constant output, no parity logic.
    assign Paridad = 1'b0;
`endif

endmodule
